lsu_byte_seq: RTL

- Load/store initiator that drives the 8-bit data memory (DMEM) port: addr, store data, store enable, load data.
- Accepts one 32-bit byte, halfword or word load/store request from the core side.
- Splits each request into little-endian byte beats on the memory port.
- Returns one response: a sign- or zero-extended load result, or a store completion, or a misalignment error.

---
 rtl/lsu_byte_seq.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/lsu_byte_seq.sv
// Byte-serial load/store initiator for an 8-bit DMEM port.
// Ports: core req/rsp (one request at a time), DMEM addr/store/load.
module lsu_byte_seq #(
  parameter int n       = 8,
  parameter int address = 11,
  parameter int XLEN    = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [1:0]         req_size_i,
  input  logic               req_unsigned_i,
  input  logic [address-1:0] req_addr_i,
  input  logic [XLEN-1:0]    req_wdata_i,
  output logic               rsp_valid_o,
  output logic [XLEN-1:0]    rsp_rdata_o,
  output logic               rsp_err_o,
  output logic [address-1:0] mem_addr_o,
  output logic [n-1:0]       mem_st_data_o,
  output logic               mem_st_en_o,
  input  logic [n-1:0]       mem_ld_data_i
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         beat_q, beat_d;
  logic               we_q, we_d;
  logic [1:0]         size_q, size_d;
  logic               uns_q, uns_d;
  logic [address-1:0] addr_q, addr_d;
  logic [XLEN-1:0]    wdata_q, wdata_d;
  logic [XLEN-1:0]    ldbuf_q, ldbuf_d;
  logic [XLEN-1:0]    rdata_q, rdata_d;
  logic               err_q, err_d;
  logic [address-1:0] maddr_q, maddr_d;
  logic [n-1:0]       mdata_q, mdata_d;

  logic [1:0]         last_beat;
  logic [1:0]         prev_beat;
  logic [address-1:0] cur_addr;
  logic [n-1:0]       cur_wbyte;
  logic [XLEN-1:0]    ld_word;
  logic               req_err;
  logic               in_access;

  function automatic logic [XLEN-1:0] extend(
    input logic [XLEN-1:0] raw,
    input logic [1:0]      sz,
    input logic            un
  );
    logic [XLEN-1:0] r;
    r = raw;
    unique case (1'b1)
      sz == 2'b00:
        r = {{(XLEN-8){~un & raw[7]}}, raw[7:0]};
      sz == 2'b01:
        r = {{(XLEN-16){~un & raw[15]}}, raw[15:0]};
      default:
        r = raw;
    endcase
    return r;
  endfunction

  always_comb begin
    last_beat = 2'd3;
    unique case (1'b1)
      size_q == 2'b00: last_beat = 2'd0;
      size_q == 2'b01: last_beat = 2'd1;
      default:         last_beat = 2'd3;
    endcase
  end

  assign prev_beat = beat_q - 2'd1;
  assign cur_addr  = addr_q + address'(beat_q);
  assign cur_wbyte = wdata_q[{beat_q, 3'b000} +: n];
  assign in_access = (state_q == S_ACCESS);

  // Final load byte arrives in DRAIN; merge it before extension.
  always_comb begin
    ld_word = ldbuf_q;
    ld_word[{beat_q, 3'b000} +: n] = mem_ld_data_i;
  end

  assign req_err =
    (req_size_i == 2'b11) ||
    (req_size_i == 2'b01 && req_addr_i[0]) ||
    (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ldbuf_d = ldbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    maddr_d = maddr_q;
    mdata_d = mdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          we_d    = req_we_i;
          size_d  = req_size_i;
          uns_d   = req_unsigned_i;
          addr_d  = req_addr_i;
          wdata_d = req_wdata_i;
          ldbuf_d = '0;
          beat_d  = '0;
          if (req_err) begin
            state_d = S_DONE;
            err_d   = 1'b1;
            rdata_d = '0;
          end else begin
            state_d = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        maddr_d = cur_addr;
        if (we_q) begin
          mdata_d = cur_wbyte;
        end else if (beat_q != 2'd0) begin
          // Read data lags the address by one beat.
          ldbuf_d[{prev_beat, 3'b000} +: n] =
            mem_ld_data_i;
        end
        if (beat_q == last_beat) begin
          if (we_q) begin
            state_d = S_DONE;
            err_d   = 1'b0;
            rdata_d = '0;
          end else begin
            state_d = S_DRAIN;
          end
        end else begin
          beat_d = beat_q + 2'd1;
        end
      end
      S_DRAIN: begin
        ldbuf_d = ld_word;
        rdata_d = extend(ld_word, size_q, uns_q);
        err_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ldbuf_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      maddr_q <= '0;
      mdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ldbuf_q <= ldbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      maddr_q <= maddr_d;
      mdata_q <= mdata_d;
    end
  end

  assign req_ready_o = (state_q == S_IDLE);
  assign rsp_valid_o = (state_q == S_DONE);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

  assign mem_addr_o =
    in_access ? cur_addr : maddr_q;
  assign mem_st_data_o =
    (in_access && we_q) ? cur_wbyte : mdata_q;
  // Reset aborts immediately: the beat in flight at the
  // reset edge must not reach DMEM.
  assign mem_st_en_o = in_access && we_q && rst_ni;

endmodule
